// File: rtl/adder_pipe_pkg.sv
// Shared elaboration helpers for the pipelined adder.
// Only constant functions live here; all widths remain module parameters.
package adder_pipe_pkg;

    // Width of one carry-chain segment. Illegal configurations fall back to 1
    // so elaboration reaches the explicit configuration check in the top.
    function automatic int unsigned chunk_bits(input int unsigned width,
                                               input int unsigned stages);
        if (stages == 0 || (width % stages) != 0) begin
            return 1;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// Combinational ripple segment: one CHUNK-wide piece of the pipelined carry chain.
module adder_slice
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES segments, one per
// stage, with a single global stall that freezes every stage while the output is blocked.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_bits(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipe: WIDTH (%0d) must be a non-zero multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_q;

    // Subtraction is A + ~B + 1; the +1 enters as the carry-in of the LSB chunk.
    assign b_eff = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unprocessed on entry, and result bits complete on exit.
        localparam int unsigned IN_W   = WIDTH - k * CHUNK;
        localparam int unsigned DONE_W = (k + 1) * CHUNK;

        logic              v_in;
        logic              cin;
        logic              co;
        logic              v_q;
        logic              c_q;
        logic [IN_W-1:0]   opa_in;
        logic [IN_W-1:0]   opb_in;
        logic [CHUNK-1:0]  sum;
        logic [DONE_W-1:0] res_d;
        logic [DONE_W-1:0] res_q;

        if (k == 0) begin : g_head
            assign v_in   = in_valid;
            assign opa_in = a;
            assign opb_in = b_eff;
            assign cin    = sub;
            assign res_d  = sum;
        end else begin : g_body
            assign v_in   = g_stage[k-1].v_q;
            assign opa_in = g_stage[k-1].g_fwd.opa_q;
            assign opb_in = g_stage[k-1].g_fwd.opb_q;
            assign cin    = g_stage[k-1].c_q;
            assign res_d  = {sum, g_stage[k-1].res_q};
        end

        adder_slice #(
            .WIDTH(CHUNK)
        ) u_slice (
            .a   (opa_in[CHUNK-1:0]),
            .b   (opb_in[CHUNK-1:0]),
            .cin (cin),
            .sum (sum),
            .cout(co)
        );

        // Data only loads on valid beats, so bubble operands never reach the outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (!stall) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= co;
                    res_q <= res_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-CHUNK-1:0] opa_q;
            logic [IN_W-CHUNK-1:0] opb_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (!stall && v_in) begin
                    opa_q <= opa_in[IN_W-1:CHUNK];
                    opb_q <= opb_in[IN_W-1:CHUNK];
                end
            end
        end else begin : g_last
            // Signed overflow is judged as the MSB chunk resolves.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall && v_in) begin
                    ovf_q <= (opa_in[IN_W-1] == opb_in[IN_W-1]) &&
                             (sum[CHUNK-1] != opa_in[IN_W-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign y         = g_stage[STAGES-1].res_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = ovf_q;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=32, STAGES=4): directed edge cases,
// randomized streams with backpressure and bubbles, and mid-flight reset.
module tb_adder_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] y;
        logic        c;
        logic        o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Reference: full-width arithmetic on (WIDTH+1) bits, returns {y, cout, ovf}.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms);
        logic [31:0] be;
        logic [32:0] full;
        logic        o;
        be   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {32'd0, ms};
        o    = (ma[31] == be[31]) && (full[31] != ma[31]);
        return {full[31:0], full[32], o};
    endfunction

    // Issue one beat into an idle pipe and wait for its result (lat = -1 on timeout).
    task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                           output logic [33:0] res, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        sub       = ts;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        sub      = 1'($urandom_range(0, 1));
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = {y, cout, ovf};
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = $urandom;
        b         = $urandom;
        sub       = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({y, cout, ovf} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got y=%h cout=%b ovf=%b expected all 0", y, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        vec_t        v;
        logic [33:0] res;
        int          lat;
        v = '{a: 32'd1, b: 32'd2, s: 1'b0, y: 32'd3, c: 1'b0, o: 1'b0};
        run_one(v.a, v.b, v.s, res, lat);
        n_checks++;
        if (res !== {v.y, v.c, v.o}) begin
            n_fail++;
            $display("FAIL add result: got y=%h cout=%b ovf=%b expected y=%h cout=%b ovf=%b",
                     res[33:2], res[1], res[0], v.y, v.c, v.o);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL add latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_carry();
        vec_t        vecs[2];
        logic [33:0] res;
        int          lat;
        vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'd1, s: 1'b0, y: 32'd0, c: 1'b1, o: 1'b0};
        vecs[1] = '{a: 32'h7FFF_FFFF, b: 32'd1, s: 1'b0, y: 32'h8000_0000, c: 1'b0, o: 1'b1};
        for (int i = 0; i < 2; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
            n_checks++;
            if (res !== {vecs[i].y, vecs[i].c, vecs[i].o}) begin
                n_fail++;
                $display("FAIL carry[%0d] result: got y=%h cout=%b ovf=%b expected y=%h cout=%b ovf=%b",
                         i, res[33:2], res[1], res[0], vecs[i].y, vecs[i].c, vecs[i].o);
            end
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL carry[%0d] latency: got %0d expected 4", i, lat);
            end
        end
    endtask

    task automatic test_sub();
        vec_t        vecs[3];
        logic [33:0] res;
        int          lat;
        vecs[0] = '{a: 32'd5, b: 32'd7, s: 1'b1, y: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0};
        vecs[1] = '{a: 32'd7, b: 32'd5, s: 1'b1, y: 32'd2, c: 1'b1, o: 1'b0};
        vecs[2] = '{a: 32'h8000_0000, b: 32'd1, s: 1'b1, y: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
            n_checks++;
            if (res !== {vecs[i].y, vecs[i].c, vecs[i].o}) begin
                n_fail++;
                $display("FAIL sub[%0d] result: got y=%h cout=%b ovf=%b expected y=%h cout=%b ovf=%b",
                         i, res[33:2], res[1], res[0], vecs[i].y, vecs[i].c, vecs[i].o);
            end
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL sub[%0d] latency: got %0d expected 4", i, lat);
            end
        end
    endtask

    // Random beats with random out_ready; optional input bubbles with garbage operands.
    task automatic test_stream(input int n, input bit bubbles, input string name);
        logic [33:0] exp_q[$];
        logic [33:0] exp_v;
        logic [33:0] prev_out;
        logic [31:0] ca;
        logic [31:0] cb;
        logic        cs;
        bit          have       = 1'b0;
        bit          prev_stall = 1'b0;
        int          sent       = 0;
        int          got        = 0;
        int          cyc        = 0;
        int          extra      = 0;
        prev_out = '0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (sent < n && (!bubbles || $urandom_range(0, 3) != 0)) begin
                if (!have) begin
                    ca   = $urandom;
                    cb   = $urandom;
                    cs   = 1'($urandom_range(0, 1));
                    have = 1'b1;
                end
                in_valid = 1'b1;
                a        = ca;
                b        = cb;
                sub      = cs;
            end else begin
                in_valid = 1'b0;
                a        = $urandom;
                b        = $urandom;
                sub      = 1'($urandom_range(0, 1));
            end
            #1;
            n_checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL %s in_ready cycle %0d: got %b expected %b", name, cyc, in_ready,
                         !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || {y, cout, ovf} !== prev_out) begin
                    n_fail++;
                    $display("FAIL %s stall hold cycle %0d: got v=%b y=%h c=%b o=%b expected v=1 y=%h c=%b o=%b",
                             name, cyc, out_valid, y, cout, ovf, prev_out[33:2], prev_out[1],
                             prev_out[0]);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected result cycle %0d: got y=%h expected no beat",
                             name, cyc, y);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({y, cout, ovf} !== exp_v) begin
                        n_fail++;
                        $display("FAIL %s beat %0d: got y=%h cout=%b ovf=%b expected y=%h cout=%b ovf=%b",
                                 name, got, y, cout, ovf, exp_v[33:2], exp_v[1], exp_v[0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ca, cb, cs));
                sent++;
                have = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {y, cout, ovf};
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d results expected %0d", name, got, n);
        end
        // Nothing further may emerge once every accepted beat has been delivered.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL %s drain: got %0d extra beats expected 0", name, extra);
        end
    endtask

    task automatic test_reset_midflight();
        logic [33:0] res;
        int          lat;
        int          stale = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            a         = $urandom;
            b         = $urandom;
            sub       = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight pre-reset out_valid: got %b expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || {y, cout, ovf} !== 34'd0) begin
            n_fail++;
            $display("FAIL midflight async clear: got v=%b y=%h c=%b o=%b expected all 0",
                     out_valid, y, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midflight stale beats: got %0d expected 0", stale);
        end
        run_one(32'd9, 32'd3, 1'b0, res, lat);
        n_checks++;
        if (res !== {32'd12, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midflight new beat: got y=%h cout=%b ovf=%b expected y=0000000c cout=0 ovf=0",
                     res[33:2], res[1], res[0]);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL midflight latency: got %0d expected 4", lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_stream(16, 1'b0, "back_to_back");
        test_stream(24, 1'b1, "bubbles");
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages (carry-chain segments).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port y  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL compute y = A + (sub ? ~B : B) + sub over WIDTH+1 bits; cout = bit WIDTH.
REQ-016 SHALL set ovf = 1 iff A[MSB] == effective-B[MSB] and y[MSB] != A[MSB].
REQ-017 SHALL split the carry chain into STAGES chunks of CHUNK = WIDTH/STAGES bits, LSB chunk first; chunk k resolved in stage k with carry registered from stage k-1.
REQ-018 SHALL carry unprocessed operand chunks and completed result chunks forward in per-stage registers with a per-stage valid bit.
REQ-019 SHALL accept a beat on a clk edge where in_valid && in_ready.
REQ-020 SHALL present a beat accepted in cycle c with out_valid = 1 in cycle c+STAGES when no stall occurs (latency = STAGES cycles).
REQ-021 SHALL sustain one beat per cycle when out_ready is held 1.
REQ-022 SHALL define stall = out_valid && !out_ready; while stalled all stage registers hold, and in_ready = !stall (combinational).
REQ-023 SHALL hold y, cout, ovf stable while out_valid && !out_ready.
REQ-024 SHALL deliver results in acceptance order, with no loss, duplication or reordering; bubbles (invalid stages) propagate and are not compressed.
REQ-025 SHALL treat in_valid = 0 beats as bubbles; operand values on those cycles do not affect outputs.
REQ-026 SHALL, for STAGES = 1, behave as a single registered adder (latency 1).
REQ-027 SHALL error at elaboration if STAGES < 1 or WIDTH % STAGES != 0.

Reset
REQ-028 SHALL, on rst = 1, clear all stage valid bits immediately (asynchronously): out_valid = 0; in_ready = 1 once stall clears.
REQ-029 SHALL reset y, cout, ovf and all stage data/carry registers to 0.
REQ-030 SHALL discard all in-flight beats when rst asserts mid-operation; no partial result is ever emitted.

Structure
REQ-031 SHALL place no shared typedefs in a package; WIDTH/STAGES remain module parameters, CHUNK is a localparam.
REQ-032 SHALL use one sub-module adder_slice (CHUNK-bit a, b, cin -> sum, cout, combinational), instantiated STAGES times via generate.
REQ-033 SHALL keep all sequential logic and handshake control in adder_pipe.

Verification (WIDTH=32, STAGES=4)
REQ-034 SHALL check a=1, b=2, sub=0 -> y=3, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-035 SHALL check a=0xFFFFFFFF, b=1 -> y=0, cout=1, ovf=0 (carry crosses all chunks); a=0x7FFFFFFF, b=1 -> y=0x80000000, ovf=1.
REQ-036 SHALL check sub=1: a=5, b=7 -> y=0xFFFFFFFE, cout=0; a=7, b=5 -> y=2, cout=1; a=0x80000000, b=1 -> y=0x7FFFFFFF, ovf=1.
REQ-037 SHALL check 16 back-to-back random beats with out_ready randomly toggled -> all 16 results match the reference model in order; y stable during stalls.
REQ-038 SHALL check rst pulsed with 3 beats in flight -> out_valid falls to 0 within the reset cycle, none of the 3 results appear afterward, a new beat 9+3 -> 12 after latency 4.
